// File: rtl/bus_arb_pkg.sv
// Shared types, constants and helpers for the 32-source round-robin bus arbiter.
package bus_arb_pkg;

    localparam int NREQ = 32;
    localparam int IDW  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    // Binary index of a one-hot vector; returns 0 for an all-zero input.
    function automatic logic [IDW-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
        logic [IDW-1:0] idx;
        idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (oh[k]) begin
                idx = idx | IDW'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick32.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping 31 -> 0.
module rr_pick32 (
    input  logic [31:0] req,
    input  logic [4:0]  ptr,
    output logic        any,
    output logic [4:0]  win_idx,
    output logic [31:0] win_onehot
);
    import bus_arb_pkg::*;

    logic [31:0] w_mask;
    logic [63:0] w_dbl;
    logic [63:0] w_first;

    // Lower half keeps only bits >= ptr; the unmasked upper copy catches the wrap.
    always_comb begin
        w_mask     = ~((32'd1 << ptr) - 32'd1);
        w_dbl      = {req, req & w_mask};
        w_first    = w_dbl & (~w_dbl + 64'd1);
        win_onehot = w_first[31:0] | w_first[63:32];
        win_idx    = onehot_to_idx(win_onehot);
        any        = |req;
    end

endmodule

// File: rtl/bus_arbiter32.sv
// Round-robin bus arbiter with one dead turnaround cycle between owners
// and an optional per-ownership hold limit (MAX_HOLD = 0 means unlimited).
//
//   state | meaning
//   IDLE  | no owner; arbitrates every cycle
//   GRANT | one owner drives the bus
//   TURN  | dead cycle between owners; arbitrates for the next owner
module bus_arbiter32 #(
    parameter int N        = 32,
    parameter int IDW      = 5,
    parameter int MAX_HOLD = 4
) (
    input  logic           clk,
    input  logic           clr,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           bus_valid,
    output logic           turn
);
    import bus_arb_pkg::*;

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

    arb_state_t     r_state;
    arb_state_t     w_next_state;
    logic [4:0]     r_ptr;
    logic [HW-1:0]  r_hold;
    logic [N-1:0]   r_grant;
    logic [IDW-1:0] r_grant_id;
    logic           r_valid;
    logic           r_turn;

    logic           w_any;
    logic [4:0]     w_win_idx;
    logic [31:0]    w_win_onehot;
    logic           w_owner_req;
    logic           w_expired;
    logic           w_award;
    logic           w_release;

    rr_pick32 u_pick (
        .req        (req),
        .ptr        (r_ptr),
        .any        (w_any),
        .win_idx    (w_win_idx),
        .win_onehot (w_win_onehot)
    );

    // The owner is identified by the registered grant index, so the release test is a single mux.
    assign w_owner_req = req[r_grant_id];
    assign w_expired   = (MAX_HOLD != 0) && (r_hold == HOLD_LAST);

    // State register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state; release and expiry in the same cycle collapse into one TURN.
    always_comb begin
        w_next_state = r_state;
        w_award      = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            IDLE, TURN: begin
                if (w_any) begin
                    w_next_state = GRANT;
                    w_award      = 1'b1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            GRANT: begin
                if (!w_owner_req || w_expired) begin
                    w_next_state = TURN;
                    w_release    = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Pointer, hold counter and registered outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_ptr      <= '0;
            r_hold     <= '0;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_valid    <= 1'b0;
            r_turn     <= 1'b0;
        end else if (w_award) begin
            r_grant    <= w_win_onehot;
            r_grant_id <= w_win_idx;
            r_valid    <= 1'b1;
            r_turn     <= 1'b0;
            r_ptr      <= w_win_idx + 5'd1;
            r_hold     <= '0;
        end else if (w_release) begin
            r_grant    <= '0;
            r_grant_id <= '0;
            r_valid    <= 1'b0;
            r_turn     <= 1'b1;
        end else if (r_state == GRANT) begin
            // With an unlimited hold the counter just parks at all-ones.
            if (r_hold != {HW{1'b1}}) begin
                r_hold <= r_hold + HW'(1);
            end
        end else begin
            r_grant    <= '0;
            r_grant_id <= '0;
            r_valid    <= 1'b0;
            r_turn     <= 1'b0;
        end
    end

    assign grant     = r_grant;
    assign grant_id  = r_grant_id;
    assign bus_valid = r_valid;
    assign turn      = r_turn;

endmodule

// File: tb/tb_bus_arbiter32.sv
// Bench for bus_arbiter32: three instances (hold limits 4, 0, 2) share clock,
// reset and requests; an ownership-level reference model predicts every output.
module tb_bus_arbiter32;

    logic        clk;
    logic        clr;
    logic [31:0] req;

    logic [31:0] d_grant [3];
    logic [4:0]  d_id    [3];
    logic        d_valid [3];
    logic        d_turn  [3];

    int checks;
    int errors;

    // Reference model: who owns the bus, how many grant cycles it has had,
    // whether the current cycle is the dead cycle, and where the next scan starts.
    int hold_lim [3];
    int m_owner  [3];
    int m_held   [3];
    int m_ptr    [3];
    bit m_turn   [3];

    bus_arbiter32 #(.N(32), .IDW(5), .MAX_HOLD(4)) u_dut0 (
        .clk(clk), .clr(clr), .req(req),
        .grant(d_grant[0]), .grant_id(d_id[0]), .bus_valid(d_valid[0]), .turn(d_turn[0])
    );
    bus_arbiter32 #(.N(32), .IDW(5), .MAX_HOLD(0)) u_dut1 (
        .clk(clk), .clr(clr), .req(req),
        .grant(d_grant[1]), .grant_id(d_id[1]), .bus_valid(d_valid[1]), .turn(d_turn[1])
    );
    bus_arbiter32 #(.N(32), .IDW(5), .MAX_HOLD(2)) u_dut2 (
        .clk(clk), .clr(clr), .req(req),
        .grant(d_grant[2]), .grant_id(d_id[2]), .bus_valid(d_valid[2]), .turn(d_turn[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < 3; i++) begin
                m_owner[i] = -1;
                m_held[i]  = 0;
                m_ptr[i]   = 0;
                m_turn[i]  = 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (m_owner[i] >= 0) begin
                    if (!req[m_owner[i]] || (hold_lim[i] != 0 && m_held[i] == hold_lim[i])) begin
                        m_owner[i] = -1;
                        m_turn[i]  = 1'b1;
                    end else begin
                        m_held[i] = m_held[i] + 1;
                    end
                end else begin
                    m_turn[i] = 1'b0;
                    if (req != 32'h0) begin
                        int  w;
                        bit  found;
                        w     = 0;
                        found = 1'b0;
                        for (int k = 0; k < 32; k++) begin
                            if (!found && req[(m_ptr[i] + k) % 32]) begin
                                w     = (m_ptr[i] + k) % 32;
                                found = 1'b1;
                            end
                        end
                        m_owner[i] = w;
                        m_held[i]  = 1;
                        m_ptr[i]   = (w + 1) % 32;
                    end
                end
            end
        end
    end

    function automatic logic [31:0] exp_grant(input int i);
        return (m_owner[i] >= 0) ? (32'h1 << m_owner[i]) : 32'h0;
    endfunction

    function automatic logic [4:0] exp_id(input int i);
        return (m_owner[i] >= 0) ? 5'(m_owner[i]) : 5'd0;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Reset pulse placed in the middle of the low phase, away from any clock edge.
    task automatic clr_pulse();
        #2 clr = 1'b1;
        #1 clr = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        req = 32'h0;
        repeat (2) tick();
        clr = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (d_grant[i] !== 32'h0 || d_id[i] !== 5'd0 || d_valid[i] !== 1'b0 || d_turn[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state[%0d]: got grant=%h id=%0d valid=%b turn=%b, want all zero",
                         i, d_grant[i], d_id[i], d_valid[i], d_turn[i]);
            end
        end
        req = 32'h20;
        tick();
        checks++;
        if (d_grant[0] !== 32'h20) begin
            errors++;
            $display("FAIL reset_pregrant: got grant=%h want 00000020", d_grant[0]);
        end
        #2 clr = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (d_grant[i] !== 32'h0 || d_id[i] !== 5'd0 || d_valid[i] !== 1'b0 || d_turn[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_async[%0d]: got grant=%h id=%0d valid=%b turn=%b, want all zero",
                         i, d_grant[i], d_id[i], d_valid[i], d_turn[i]);
            end
        end
        clr = 1'b0;
        req = 32'h11;
        tick();
        checks++;
        if (d_grant[0] !== 32'h1 || d_id[0] !== 5'd0) begin
            errors++;
            $display("FAIL reset_first_grant: got grant=%h id=%0d want 00000001 id 0", d_grant[0], d_id[0]);
        end
    endtask

    task automatic test_single();
        req = 32'h0;
        repeat (3) tick();
        req = 32'h20;
        for (int e = 0; e < 3; e++) begin
            tick();
            checks++;
            if (d_grant[0] !== 32'h20 || d_id[0] !== 5'd5 || d_valid[0] !== 1'b1 || d_turn[0] !== 1'b0) begin
                errors++;
                $display("FAIL single_grant edge%0d: got grant=%h id=%0d valid=%b turn=%b want 00000020/5/1/0",
                         e, d_grant[0], d_id[0], d_valid[0], d_turn[0]);
            end
        end
        req = 32'h0;
        tick();
        checks++;
        if (d_grant[0] !== 32'h0 || d_turn[0] !== 1'b1 || d_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_release: got grant=%h turn=%b valid=%b want 0/1/0",
                     d_grant[0], d_turn[0], d_valid[0]);
        end
        tick();
        checks++;
        if (d_grant[0] !== 32'h0 || d_turn[0] !== 1'b0 || d_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got grant=%h turn=%b valid=%b want 0/0/0",
                     d_grant[0], d_turn[0], d_valid[0]);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] want;
        clr_pulse();
        req = 32'h11;
        for (int c = 0; c < 30; c++) begin
            tick();
            case (c % 10)
                0, 1, 2, 3: want = 32'h1;
                5, 6, 7, 8: want = 32'h10;
                default:    want = 32'h0;
            endcase
            checks++;
            if (d_grant[0] !== want || d_turn[0] !== (want == 32'h0)) begin
                errors++;
                $display("FAIL rr_hold cycle%0d: got grant=%h turn=%b want grant=%h", c, d_grant[0], d_turn[0], want);
            end
        end
    endtask

    task automatic test_wrap();
        req = 32'h0;
        clr_pulse();
        req = 32'h8000_0000;
        tick();
        req = 32'h8000_0001;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (d_grant[0] !== 32'h8000_0000 || d_id[0] !== 5'd31) begin
                errors++;
                $display("FAIL wrap_owner31 cycle%0d: got grant=%h id=%0d", c, d_grant[0], d_id[0]);
            end
        end
        tick();
        checks++;
        if (d_turn[0] !== 1'b1 || d_grant[0] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_turn: got turn=%b grant=%h want 1/0", d_turn[0], d_grant[0]);
        end
        tick();
        checks++;
        if (d_grant[0] !== 32'h1 || d_id[0] !== 5'd0) begin
            errors++;
            $display("FAIL wrap_next: got grant=%h id=%0d want 00000001 id 0", d_grant[0], d_id[0]);
        end
    endtask

    task automatic test_unlimited();
        int bad;
        req = 32'h0;
        clr_pulse();
        req = 32'h88;
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (d_grant[1] !== 32'h8 || d_id[1] !== 5'd3 || d_turn[1] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL unlimited_hold: %0d of 100 cycles lost 00000008, last grant=%h", bad, d_grant[1]);
        end
        req = 32'h80;
        tick();
        checks++;
        if (d_grant[1] !== 32'h0 || d_turn[1] !== 1'b1) begin
            errors++;
            $display("FAIL unlimited_turn: got grant=%h turn=%b want 0/1", d_grant[1], d_turn[1]);
        end
        tick();
        checks++;
        if (d_grant[1] !== 32'h80 || d_id[1] !== 5'd7) begin
            errors++;
            $display("FAIL unlimited_next: got grant=%h id=%0d want 00000080 id 7", d_grant[1], d_id[1]);
        end
    endtask

    task automatic test_sole_expiry();
        logic [31:0] want;
        req = 32'h0;
        clr_pulse();
        req = 32'h200;
        for (int c = 0; c < 15; c++) begin
            tick();
            want = ((c % 3) == 2) ? 32'h0 : 32'h200;
            checks++;
            if (d_grant[2] !== want || d_turn[2] !== (want == 32'h0) ||
                (want != 32'h0 && d_id[2] !== 5'd9)) begin
                errors++;
                $display("FAIL sole_expiry cycle%0d: got grant=%h id=%0d turn=%b want grant=%h",
                         c, d_grant[2], d_id[2], d_turn[2], want);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            case ($urandom_range(0, 4))
                0:       req = 32'h0;
                1:       req = 32'h1 << $urandom_range(0, 31);
                2:       req = $urandom & $urandom;
                3:       req = $urandom;
                default: req = req;
            endcase
            if ($urandom_range(0, 59) == 0) clr_pulse();
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (d_grant[i] !== exp_grant(i) || d_id[i] !== exp_id(i) ||
                    d_valid[i] !== (m_owner[i] >= 0) || d_turn[i] !== m_turn[i]) begin
                    errors++;
                    $display("FAIL rand_model[%0d] cycle%0d: got grant=%h id=%0d valid=%b turn=%b want grant=%h id=%0d turn=%b",
                             i, c, d_grant[i], d_id[i], d_valid[i], d_turn[i], exp_grant(i), exp_id(i), m_turn[i]);
                end
                checks++;
                if ($countones(d_grant[i]) > 1 || d_valid[i] !== (d_grant[i] != 32'h0)) begin
                    errors++;
                    $display("FAIL rand_invariant[%0d] cycle%0d: grant=%h valid=%b", i, c, d_grant[i], d_valid[i]);
                end
            end
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        hold_lim[0] = 4;
        hold_lim[1] = 0;
        hold_lim[2] = 2;
        clr         = 1'b1;
        req         = 32'h0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_unlimited();
        test_sole_expiry();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter32.md
# bus_arbiter32

Round-robin arbiter for the shared 32-source datapath bus. Accepts one request line per bus driver, issues a registered one-hot grant that drives the bus source encoder, and reports the winner's 5-bit index. Enforces a one-cycle dead turnaround between owners, preventing two drivers from overlapping on the bus, and enforces an optional maximum hold time per grant.

## Interface
- N, 32: number of requesters. Fixed at 32; the parameter exists for readability only.
- IDW, 5: grant index width.
- MAX_HOLD, 4: maximum consecutive grant cycles per ownership. 0 means unlimited.

- clk  in  1  rising-edge clock.
- clr  in  1  reset, asynchronous, active-high.
- req  in  32  request per bus driver. A requester holds its bit high while it wants or uses the bus.
- grant  out  32  registered one-hot grant, or all-zero. Bit k connects to bus encoder input k.
- grant_id  out  5  binary index of the set grant bit. 0 when no grant is set.
- bus_valid  out  1  high exactly when grant is non-zero.
- turn  out  1  high during the turnaround cycle.

## Operation
- States:
  - IDLE: no owner; arbitrates every cycle.
  - GRANT: an owner holds the bus.
  - TURN: one dead cycle; arbitrates in this cycle.
- Arbitration:
  - Winner = first set req bit scanning upward from ptr, wrapping 31 -> 0.
  - On award: ptr <= (winner + 1) mod 32.
- Transitions at each clk edge:
  - IDLE, req != 0: go to GRANT; grant <= onehot(winner); hold_cnt <= 0.
  - IDLE, req == 0: stay in IDLE.
  - GRANT, req[owner] == 0: go to TURN.
  - GRANT, MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1: go to TURN (expiry).
  - GRANT, otherwise: stay; hold_cnt increments.
  - TURN, req != 0: go to GRANT with the new winner.
  - TURN, req == 0: go to IDLE.
- Expired owner:
  - It still requesting is fine; ptr has already moved past it, so it has lowest priority.
  - If it is the only requester, it is re-granted after the dead cycle.
- Width rules:
  - hold_cnt is wide enough for MAX_HOLD-1 and saturates when MAX_HOLD = 0.
  - ptr is 5 bits and wraps naturally.
- Invariants: grant is never multi-hot; grant_id always equals the encoder mapping of grant.
- Requests raised by non-owners during GRANT have no effect until the next arbitration.

## Timing
- Reset (clr high, asynchronous): state IDLE; grant 0; grant_id 0; bus_valid 0; turn 0; ptr 0; hold_cnt 0. Takes effect immediately, including mid-grant. After release, requester 0 has highest priority.
- Grant latency: req sampled at edge t in IDLE -> grant, grant_id and bus_valid valid after edge t (one cycle).
- Release: owner's req low at edge t -> grant 0 and turn 1 after t. The next owner's grant follows after edge t+1. There is always exactly one dead cycle between owners.
- Hold: an owner with MAX_HOLD = m receives exactly m consecutive grant cycles before TURN.
- Simultaneous release and expiry: treated as one TURN.
- All outputs are registered; there is no combinational path from req to grant.

## Structure
- Package bus_arb_pkg:
  - state enum {IDLE, GRANT, TURN};
  - constants NREQ = 32 and IDW = 5;
  - function onehot_to_idx.
- Sub-module rr_pick32 (combinational): inputs req[31:0] and ptr[4:0]; outputs any, win_idx[4:0], win_onehot[31:0]. Implemented as a double-width masked priority scan.
- Top level contains only the FSM, ptr, hold_cnt and output registers.

## Test plan
- Reset: clr pulsed between edges while grant = 32'h20 -> grant, grant_id, bus_valid and turn all 0 immediately. First later request set 0x11 -> grant 32'h1.
- Single request: req = 32'h20 from IDLE at edge 0 -> grant = 32'h20 and grant_id = 5 after edge 0. req drops before edge 3 -> turn = 1 and grant = 0 after edge 3; IDLE after edge 4.
- Round-robin with hold, MAX_HOLD = 4, req = 32'h11 constant -> repeating pattern:
  - grant 32'h1 for 4 cycles;
  - 1 dead cycle;
  - grant 32'h10 for 4 cycles;
  - 1 dead cycle.
- Wrap-around: previous owner 31, req = 32'h8000_0001 -> next grant 32'h1 with grant_id 0.
- Unlimited hold, MAX_HOLD = 0: req[3] held 100 cycles with req[7] also high -> grant stays 32'h8 throughout. When req[3] drops -> one dead cycle, then grant 32'h80.
- Expired sole requester: MAX_HOLD = 2, only req[9] high -> repeating pattern of 2 grant cycles then 1 turn cycle; grant_id stays 9 in every grant cycle.
